// File: rtl/gate_sweep_checker.sv
// Purpose: exhaustive sweep of an N-input gate against a golden AND/OR/XOR/NAND reduction model.
// Latency: each vector takes SETTLE+1 cycles, so busy lasts 2^N*(SETTLE+1) cycles and done follows on the next cycle.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while busy. Option macro: GATE_SWEEP_STOP_ON_FAIL_EN.
module gate_sweep_checker #(
    parameter int N      = 2,
    parameter int SETTLE = 1,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    output logic [N-1:0]  dut_in,
    input  logic          dut_out,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] err_count,
    output logic [N-1:0]  first_fail,
    output logic          first_fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int            SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);
    // One extra bit keeps the last-vector compare unambiguous.
    localparam logic [N:0]    VEC_LAST    = {1'b0, {N{1'b1}}};
    localparam logic [CW-1:0] ERR_MAX     = {CW{1'b1}};

    state_t        state, state_nx;
    logic [N:0]    vec;
    logic [SW-1:0] settle_cnt;
    logic [1:0]    op_q;
    logic          golden;
    logic          mismatch;
    logic          accept;
    logic          last_vec;

    assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_vec = (vec == VEC_LAST);
    assign mismatch = (dut_out != golden);

    assign dut_in = vec[N-1:0];
    assign busy   = (state == S_SETTLE) || (state == S_CHECK);
    assign done   = (state == S_DONE);
    assign pass   = done && (err_count == '0);

    // Golden model: the latched operation reduced across every bit of the current vector.
    always_comb begin
        golden = 1'b0;
        case (op_q)
            2'b00:   golden = &vec[N-1:0];
            2'b01:   golden = |vec[N-1:0];
            2'b10:   golden = ^vec[N-1:0];
            default: golden = ~&vec[N-1:0];
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic for the sweep sequencer.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nx = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt == '0) state_nx = S_CHECK;
            end
            S_CHECK: begin
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                if (mismatch || last_vec) state_nx = S_DONE;
                else                      state_nx = S_SETTLE;
`else
                if (last_vec) state_nx = S_DONE;
                else          state_nx = S_SETTLE;
`endif
            end
            S_DONE: begin
                if (accept) state_nx = S_SETTLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: vector walk, settle timer, latched op and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec              <= '0;
            settle_cnt       <= '0;
            op_q             <= 2'b00;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else if (accept) begin
            vec              <= '0;
            settle_cnt       <= SETTLE_LOAD;
            op_q             <= op;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                S_SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                        // Only the earliest failing vector is kept.
                        if (!first_fail_valid) begin
                            first_fail       <= vec[N-1:0];
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (state_nx == S_SETTLE) begin
                        vec        <= vec + 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed checks of the gate sweep checker on a 2-input and a 3-input instance.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
// Every wait for done is bounded by a cycle budget.
module tb_gate_sweep_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // 2-input instance
    logic       start_a = 1'b0;
    logic [1:0] op_a = 2'b00;
    logic [1:0] dut_in_a;
    logic       dut_out_a;
    logic       busy_a, done_a, pass_a;
    logic [3:0] err_a;
    logic [1:0] ff_a;
    logic       ffv_a;
    logic       gate_nand = 1'b0;

    // 3-input instance, narrow error counter, output tied low
    logic       start_b = 1'b0;
    logic [1:0] op_b = 2'b00;
    logic [2:0] dut_in_b;
    logic       busy_b, done_b, pass_b;
    logic [1:0] err_b;
    logic [2:0] ff_b;
    logic       ffv_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc, busy_cnt;
    logic [1:0] din_log [0:15];

    always #5 clk = ~clk;

    assign dut_out_a = gate_nand ? ~&dut_in_a : &dut_in_a;

    gate_sweep_checker #(.N(2), .SETTLE(1), .CW(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .op(op_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_fail(ff_a), .first_fail_valid(ffv_a)
    );

    gate_sweep_checker #(.N(3), .SETTLE(1), .CW(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .op(op_b),
        .dut_in(dut_in_b), .dut_out(1'b0),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_fail(ff_b), .first_fail_valid(ffv_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on instance A, then count cycles until done (cycle 1 = first
    // cycle after the sampling edge). At cycle 'poke' start and op are toggled.
    task automatic sweep_a(input logic [1:0] op_v, input int poke,
                           output int c, output int bc);
        op_a    = op_v;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        c  = 1;
        bc = 0;
        while (!done_a && c < 100) begin
            if (busy_a) bc++;
            if (c < 16) din_log[c] = dut_in_a;
            if (c == poke) begin
                start_a = 1'b1;
                op_a    = ~op_v;
            end else begin
                start_a = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        start_a = 1'b0;
        if (c >= 100) chk("sweep_a_timeout", 32'(c), 32'd0);
    endtask

    initial begin
        // Reset values
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_dut_in", 32'(dut_in_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_pass", 32'(pass_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_ffv", 32'(ffv_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_stay_busy", 32'(busy_a), 32'd0);
        chk("idle_stay_done", 32'(done_a), 32'd0);

        // 1: correct AND gate, op AND
        gate_nand = 1'b0;
        sweep_a(2'b00, 0, cyc, busy_cnt);
        chk("t1_done_cycle", 32'(cyc), 32'd9);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("t1_vec0", 32'(din_log[1]), 32'd0);
        chk("t1_vec1", 32'(din_log[3]), 32'd1);
        chk("t1_vec2", 32'(din_log[5]), 32'd2);
        chk("t1_vec3", 32'(din_log[7]), 32'd3);
        chk("t1_pass", 32'(pass_a), 32'd1);
        chk("t1_err", 32'(err_a), 32'd0);
        chk("t1_ffv", 32'(ffv_a), 32'd0);
        chk("t1_dut_in_hold", 32'(dut_in_a), 32'd3);
        repeat (3) @(negedge clk);
        chk("t1_done_hold", 32'(done_a), 32'd1);

        // 2: AND gate checked against XOR, restarted from DONE
        sweep_a(2'b10, 0, cyc, busy_cnt);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        chk("t2_err", 32'(err_a), 32'd1);
        chk("t2_dut_in", 32'(dut_in_a), 32'd1);
`else
        chk("t2_err", 32'(err_a), 32'd3);
        chk("t2_done_cycle", 32'(cyc), 32'd9);
`endif
        chk("t2_ff", 32'(ff_a), 32'd1);
        chk("t2_ffv", 32'(ffv_a), 32'd1);
        chk("t2_pass", 32'(pass_a), 32'd0);

        // 3: N=3, zero output, op OR, 2-bit counter saturates
        op_b    = 2'b01;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 1;
        while (!done_b && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) chk("t3_timeout", 32'(cyc), 32'd0);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        chk("t3_err", 32'(err_b), 32'd1);
`else
        chk("t3_done_cycle", 32'(cyc), 32'd17);
        chk("t3_err_sat", 32'(err_b), 32'd3);
`endif
        chk("t3_ff", 32'(ff_b), 32'd1);
        chk("t3_ffv", 32'(ffv_b), 32'd1);
        chk("t3_pass", 32'(pass_b), 32'd0);

        // 4: reset during SETTLE of vector 10
        op_a    = 2'b00;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 0;
        while (!(busy_a && dut_in_a == 2'd2) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("t4_reach_vec2", 32'(cyc < 50), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_rst_busy", 32'(busy_a), 32'd0);
        chk("t4_rst_dut_in", 32'(dut_in_a), 32'd0);
        chk("t4_rst_done", 32'(done_a), 32'd0);
        chk("t4_rst_err", 32'(err_a), 32'd0);
        @(negedge clk);
        chk("t4_idle_after", 32'(busy_a), 32'd0);
        sweep_a(2'b00, 0, cyc, busy_cnt);
        chk("t4_resweep_cycle", 32'(cyc), 32'd9);
        chk("t4_resweep_pass", 32'(pass_a), 32'd1);

        // 5: start/op toggled mid-sweep is ignored; start in DONE restarts
        sweep_a(2'b00, 3, cyc, busy_cnt);
        chk("t5_no_restart_cycle", 32'(cyc), 32'd9);
        chk("t5_latched_op_pass", 32'(pass_a), 32'd1);
        chk("t5_latched_op_err", 32'(err_a), 32'd0);
        op_a    = 2'b10;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("t5_restart_done_clr", 32'(done_a), 32'd0);
        chk("t5_restart_busy", 32'(busy_a), 32'd1);
        cyc = 1;
        while (!done_a && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) chk("t5_timeout", 32'(cyc), 32'd0);
`ifndef GATE_SWEEP_STOP_ON_FAIL_EN
        chk("t5_restart_err", 32'(err_a), 32'd3);
`endif

        // 6: NAND gate against op AND -> vector 00 already fails
        gate_nand = 1'b1;
        sweep_a(2'b00, 0, cyc, busy_cnt);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        chk("t6_done_cycle", 32'(cyc), 32'd3);
        chk("t6_err", 32'(err_a), 32'd1);
        chk("t6_dut_in", 32'(dut_in_a), 32'd0);
`else
        chk("t6_done_cycle", 32'(cyc), 32'd9);
        chk("t6_err", 32'(err_a), 32'd4);
        chk("t6_dut_in", 32'(dut_in_a), 32'd3);
`endif
        chk("t6_ff", 32'(ff_a), 32'd0);
        chk("t6_ffv", 32'(ffv_a), 32'd1);
        chk("t6_pass", 32'(pass_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
